cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have parameters: PC_WIDTH, default 16, program-counter width; CNT_WIDTH, default 32, retired-instruction counter width; MEM_TIMEOUT, default 15, maximum MEMW ticks before fault.
REQ-002 clk_pi  in  1  single system clock; all state changes on its rising edge.
REQ-003 reset_pi  in  1  reset, synchronous and active-high.
REQ-004 tick_pi  in  1  clock-divider enable; the FSM advances only in cycles where tick_pi=1.
REQ-005 run_pi  in  1  1=free-run, 0=single-step mode.
REQ-006 step_pi  in  1  raw step button level.
REQ-007 resume_pi  in  1  raw resume button level.
REQ-008 halt_cmd_pi  in  1  decoded HALT for the current instruction.
REQ-009 rst_cmd_pi  in  1  decoded RST for the current instruction.
REQ-010 mem_access_pi  in  1  current instruction is a load or store.
REQ-011 mem_ready_pi  in  1  data memory completes the access this cycle.
REQ-012 pc_pi  in  PC_WIDTH  current program counter.
REQ-013 bp_addr_pi  in  PC_WIDTH  breakpoint address.
REQ-014 bp_en_pi  in  1  breakpoint enable.
REQ-015 commit_po  out  1  register file, PC and data-memory write enable.
REQ-016 core_reset_po  out  1  reset to the register file, PC and data memory.
REQ-017 state_po  out  3  state encoding: RST=0, FETCH=1, EXEC=2, MEMW=3, COMMIT=4, HALT=5, WSTEP=6.
REQ-018 halted_po  out  1  high while state is HALT.
REQ-019 instr_count_po  out  CNT_WIDTH  count of retired instructions.
REQ-020 mem_timeout_po  out  1  sticky memory-timeout fault flag.

Function
REQ-021 Rising edges of step_pi and resume_pi SHALL be detected every clk_pi cycle, independent of tick_pi, using a registered previous level.
REQ-022 A step edge SHALL set a step-pending bit only while the state is COMMIT or WSTEP; step edges in all other states are discarded.
REQ-023 RST: core_reset_po=1; on tick, the FSM SHALL go to FETCH.
REQ-024 FETCH, on tick: if bp_en_pi=1, pc_pi==bp_addr_pi and bp_skip=0, the FSM SHALL go to HALT; otherwise it SHALL go to EXEC. bp_skip SHALL clear on any exit from FETCH.
REQ-025 EXEC, on tick, in this priority order: rst_cmd_pi -> RST; halt_cmd_pi -> HALT; mem_access_pi=1 and mem_ready_pi=0 -> MEMW; otherwise -> COMMIT.
REQ-026 The wait counter SHALL clear on entry to MEMW and increment on each MEMW tick with mem_ready_pi=0.
REQ-027 MEMW, on tick: mem_ready_pi=1 -> COMMIT. Otherwise, when the wait counter equals MEM_TIMEOUT-1, the FSM SHALL set mem_timeout_po and go to HALT with no commit.
REQ-028 commit_po SHALL equal (state==COMMIT) AND tick_pi, i.e. one clk cycle per instruction. It SHALL never assert in any other state.
REQ-029 COMMIT, on tick: instr_count_po SHALL increment modulo 2^CNT_WIDTH. The next state SHALL be FETCH if run_pi=1, else WSTEP.
REQ-030 WSTEP, on tick: if run_pi=1 or step-pending=1, the FSM SHALL go to FETCH and clear step-pending.
REQ-031 HALT: halted_po=1. On a resume edge, the FSM SHALL go to FETCH on the next tick and set bp_skip=1, so the breakpoint address executes once. Resume edges outside HALT SHALL be ignored.
REQ-032 Minimum latency SHALL be 3 ticks per instruction (FETCH, EXEC, COMMIT) plus 1 tick per MEMW wait.
REQ-033 halt_cmd_pi and rst_cmd_pi SHALL be sampled only in EXEC.
REQ-034 The HALT state SHALL hold until resume_pi or reset_pi, regardless of run_pi.

Reset
REQ-035 When reset_pi=1, regardless of tick_pi, the block SHALL load: state=RST, instr_count_po=0, mem_timeout_po=0, step-pending=0, bp_skip=0, wait counter=0, and edge registers set to the current input levels.
REQ-036 core_reset_po SHALL be 1 while reset_pi=1 or state==RST. commit_po and halted_po SHALL be 0 during reset.
REQ-037 reset_pi asserted mid-instruction, including in MEMW, SHALL abort the instruction with no commit.
REQ-038 rst_cmd_pi SHALL reset the core through RST but SHALL NOT clear instr_count_po or mem_timeout_po.

Verification
REQ-039 Scenario, free run: run=1, tick every cycle, no memory access -> state sequence 1,2,4,1,...; commit_po high 1 cycle in 3; instr_count_po=5 after 15 ticks.
REQ-040 Scenario, memory wait: mem_access=1 and mem_ready low for 2 ticks -> state sequence 2,3,3,4; exactly one commit; latency 5 ticks.
REQ-041 Scenario, memory timeout: MEM_TIMEOUT=4, mem_ready stuck at 0 -> HALT after 4 MEMW ticks; mem_timeout_po=1; instr_count_po unchanged.
REQ-042 Scenario, breakpoint: bp_en=1, bp_addr=0x0003 -> halt with pc=3; a resume pulse gives FETCH with no re-halt and 1 commit for pc 3; the next pass through pc=3 halts again.
REQ-043 Scenario, single step: run=0 -> parks in WSTEP; 1 step pulse gives exactly 1 commit; step pulses while in EXEC are ignored.
REQ-044 Scenario, reset: reset_pi asserted during MEMW with tick=0 -> next cycle state=0, core_reset_po=1, counters=0, no commit pulse.

Source files
------------

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - instruction sequencer FSM with step, breakpoint and memory-wait control
module cpu_sequencer #(
  parameter int PC_WIDTH    = 16,
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk_pi,
  input  logic                 reset_pi,
  input  logic                 tick_pi,
  input  logic                 run_pi,
  input  logic                 step_pi,
  input  logic                 resume_pi,
  input  logic                 halt_cmd_pi,
  input  logic                 rst_cmd_pi,
  input  logic                 mem_access_pi,
  input  logic                 mem_ready_pi,
  input  logic [PC_WIDTH-1:0]  pc_pi,
  input  logic [PC_WIDTH-1:0]  bp_addr_pi,
  input  logic                 bp_en_pi,
  output logic                 commit_po,
  output logic                 core_reset_po,
  output logic [2:0]           state_po,
  output logic                 halted_po,
  output logic [CNT_WIDTH-1:0] instr_count_po,
  output logic                 mem_timeout_po
);

  // Wait counter only ever holds 0..MEM_TIMEOUT-1; the last value triggers the fault.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEMW   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_HALT   = 3'd5,
    ST_WSTEP  = 3'd6
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 step_prev;
  logic                 resume_prev;
  logic                 step_pending;
  logic                 resume_pending;
  logic                 bp_skip;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [CNT_WIDTH-1:0] instr_count;
  logic                 mem_timeout;

  logic step_edge;
  logic resume_edge;
  logic resume_go;
  logic bp_hit;
  logic step_go;

  assign step_edge   = step_pi & ~step_prev;
  assign resume_edge = resume_pi & ~resume_prev;
  // A resume edge arriving on the same cycle as the tick releases HALT immediately.
  assign resume_go   = resume_edge | resume_pending;
  assign bp_hit      = bp_en_pi && (pc_pi == bp_addr_pi) && !bp_skip;
  assign step_go     = run_pi | step_pending;

  // State register
  always_ff @(posedge clk_pi) begin
    if (reset_pi) state <= ST_RST;
    else          state <= state_next;
  end

  // Next-state selection, advancing only on divider ticks
  always_comb begin
    state_next = state;
    if (tick_pi) begin
      case (state)
        ST_RST:    state_next = ST_FETCH;
        ST_FETCH:  state_next = bp_hit ? ST_HALT : ST_EXEC;
        ST_EXEC: begin
          if (rst_cmd_pi)                         state_next = ST_RST;
          else if (halt_cmd_pi)                   state_next = ST_HALT;
          else if (mem_access_pi && !mem_ready_pi) state_next = ST_MEMW;
          else                                    state_next = ST_COMMIT;
        end
        ST_MEMW: begin
          if (mem_ready_pi)               state_next = ST_COMMIT;
          else if (wait_cnt == WAIT_LAST) state_next = ST_HALT;
        end
        ST_COMMIT: state_next = run_pi ? ST_FETCH : ST_WSTEP;
        ST_HALT:   if (resume_go) state_next = ST_FETCH;
        ST_WSTEP:  if (step_go) state_next = ST_FETCH;
        default:   state_next = ST_RST;
      endcase
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    commit_po      = (state == ST_COMMIT) && tick_pi && !reset_pi;
    core_reset_po  = reset_pi || (state == ST_RST);
    halted_po      = (state == ST_HALT) && !reset_pi;
    state_po       = state;
    instr_count_po = instr_count;
    mem_timeout_po = mem_timeout;
  end

  // Button edge tracking, pending flags, wait counter and retired-instruction count
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      step_prev      <= step_pi;
      resume_prev    <= resume_pi;
      step_pending   <= 1'b0;
      resume_pending <= 1'b0;
      bp_skip        <= 1'b0;
      wait_cnt       <= '0;
      instr_count    <= '0;
      mem_timeout    <= 1'b0;
    end else begin
      step_prev   <= step_pi;
      resume_prev <= resume_pi;

      // Leaving WSTEP consumes the step; only COMMIT/WSTEP may arm it.
      if (tick_pi && (state == ST_WSTEP) && step_go)
        step_pending <= 1'b0;
      else if (step_edge && ((state == ST_COMMIT) || (state == ST_WSTEP)))
        step_pending <= 1'b1;

      // Resume is remembered across non-tick cycles, but only while halted.
      if ((state != ST_HALT) || (tick_pi && resume_go))
        resume_pending <= 1'b0;
      else if (resume_edge)
        resume_pending <= 1'b1;

      // The skip lets the breakpoint instruction run once after a resume.
      if (tick_pi && (state == ST_HALT) && resume_go)
        bp_skip <= 1'b1;
      else if (tick_pi && (state == ST_FETCH))
        bp_skip <= 1'b0;

      if (state != ST_MEMW)
        wait_cnt <= '0;
      else if (tick_pi && !mem_ready_pi && (wait_cnt != WAIT_LAST))
        wait_cnt <= wait_cnt + WAIT_W'(1);

      if (tick_pi && (state == ST_COMMIT))
        instr_count <= instr_count + CNT_WIDTH'(1);

      if (tick_pi && (state == ST_MEMW) && !mem_ready_pi && (wait_cnt == WAIT_LAST))
        mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer against a cycle reference model
module tb_cpu_sequencer;

  localparam int TMO = 4;
  localparam int S_RST = 0, S_FETCH = 1, S_EXEC = 2, S_MEMW = 3,
                 S_COMMIT = 4, S_HALT = 5, S_WSTEP = 6;

  typedef struct {
    bit reset, tick, run, step, resume, halt_cmd, rst_cmd;
    bit mem_access, mem_ready, bp_en;
    bit [15:0] bp_addr;
  } stim_t;

  typedef struct {
    bit        known;
    bit [2:0]  state;
    bit        commit, core_reset, halted, tmo;
    bit [31:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic reset, tick, run, step, resume, halt_cmd, rst_cmd;
  logic mem_access, mem_ready, bp_en;
  logic [15:0] pc, bp_addr;
  logic commit, core_reset, halted, mem_timeout;
  logic [2:0] state;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_WIDTH(16), .CNT_WIDTH(32), .MEM_TIMEOUT(TMO)) dut (
    .clk_pi(clk), .reset_pi(reset), .tick_pi(tick), .run_pi(run),
    .step_pi(step), .resume_pi(resume), .halt_cmd_pi(halt_cmd),
    .rst_cmd_pi(rst_cmd), .mem_access_pi(mem_access), .mem_ready_pi(mem_ready),
    .pc_pi(pc), .bp_addr_pi(bp_addr), .bp_en_pi(bp_en),
    .commit_po(commit), .core_reset_po(core_reset), .state_po(state),
    .halted_po(halted), .instr_count_po(instr_count), .mem_timeout_po(mem_timeout)
  );

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Reference model state: what the sequencer should be doing, tracked per clock.
  bit        m_known = 0;
  int        m_state = S_RST;
  bit [31:0] m_cnt = 0;
  bit        m_tmo = 0, m_step_arm = 0, m_resume_arm = 0, m_skip = 0;
  int        m_stall_ticks = 0;
  bit        m_step_lvl = 0, m_resume_lvl = 0;
  bit [15:0] tb_pc = 0;

  stim_t cur;

  task automatic model_cycle(input stim_t s, input bit [15:0] p, output exp_t e);
    bit step_rise, resume_rise, armed_before;
    e.known      = m_known;
    e.state      = 3'(m_state);
    e.commit     = !s.reset && (m_state == S_COMMIT) && s.tick;
    e.core_reset = s.reset || (m_state == S_RST);
    e.halted     = !s.reset && (m_state == S_HALT);
    e.count      = m_cnt;
    e.tmo        = m_tmo;
    step_rise    = s.step && !m_step_lvl;
    resume_rise  = s.resume && !m_resume_lvl;
    m_step_lvl   = s.step;
    m_resume_lvl = s.resume;
    if (s.reset) begin
      m_known = 1; m_state = S_RST; m_cnt = 0; m_tmo = 0;
      m_step_arm = 0; m_resume_arm = 0; m_skip = 0; m_stall_ticks = 0;
      return;
    end
    if (!m_known) return;
    armed_before = m_step_arm;
    if (step_rise && (m_state == S_COMMIT || m_state == S_WSTEP)) m_step_arm = 1;
    if (m_state != S_HALT) m_resume_arm = 0;
    else if (resume_rise) m_resume_arm = 1;
    if (!s.tick) return;
    case (m_state)
      S_RST: m_state = S_FETCH;
      S_FETCH: begin
        m_state = (s.bp_en && p == s.bp_addr && !m_skip) ? S_HALT : S_EXEC;
        m_skip = 0;
      end
      S_EXEC: begin
        if (s.rst_cmd) m_state = S_RST;
        else if (s.halt_cmd) m_state = S_HALT;
        else if (s.mem_access && !s.mem_ready) begin
          m_state = S_MEMW; m_stall_ticks = 0;
        end else m_state = S_COMMIT;
      end
      S_MEMW: begin
        if (s.mem_ready) m_state = S_COMMIT;
        else begin
          m_stall_ticks++;
          if (m_stall_ticks == TMO) begin m_tmo = 1; m_state = S_HALT; end
        end
      end
      S_COMMIT: begin
        m_cnt++;
        m_state = s.run ? S_FETCH : S_WSTEP;
      end
      S_HALT: if (m_resume_arm) begin
        m_state = S_FETCH; m_skip = 1; m_resume_arm = 0;
      end
      S_WSTEP: if (s.run || armed_before) begin
        m_state = S_FETCH; m_step_arm = 0;
      end
      default: m_state = S_RST;
    endcase
  endtask

  // Apply one cycle of stimulus and queue the response the model predicts for it.
  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    reset = s.reset; tick = s.tick; run = s.run; step = s.step;
    resume = s.resume; halt_cmd = s.halt_cmd; rst_cmd = s.rst_cmd;
    mem_access = s.mem_access; mem_ready = s.mem_ready;
    bp_en = s.bp_en; bp_addr = s.bp_addr; pc = tb_pc;
    model_cycle(s, tb_pc, e);
    if (e.core_reset) tb_pc = 0;
    else if (e.commit) tb_pc = (tb_pc + 16'd1) & 16'd7;
    exp_q.push_back(e);
  endtask

  task automatic drive_n(input int n);
    for (int i = 0; i < n; i++) drive(cur);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, want);
    end
  endtask

  // Monitor: every presented cycle is popped and checked mid-period.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("commit", 32'(commit), 32'(e.commit));
      chk("core_reset", 32'(core_reset), 32'(e.core_reset));
      chk("halted", 32'(halted), 32'(e.halted));
      if (e.known) begin
        chk("state", 32'(state), 32'(e.state));
        chk("instr_count", instr_count, e.count);
        chk("mem_timeout", 32'(mem_timeout), 32'(e.tmo));
      end
    end
  end

  initial begin
    int tick_pct, ready_pct;
    cur = '{default: 0};
    cur.bp_addr = 16'd3;
    reset = 1; tick = 0; run = 0; step = 0; resume = 0; halt_cmd = 0; rst_cmd = 0;
    mem_access = 0; mem_ready = 0; bp_en = 0; bp_addr = 0; pc = 0;

    // Free run: 15 ticks without memory traffic.
    cur.reset = 1; cur.tick = 1; cur.run = 1;
    drive_n(2);
    cur.reset = 0;
    drive_n(15);

    // Memory wait: ready comes every third cycle.
    cur.mem_access = 1;
    for (int i = 0; i < 24; i++) begin
      cur.mem_ready = (i % 3 == 2);
      drive(cur);
    end

    // Memory timeout: ready stuck low until the fault halts the core.
    cur.mem_ready = 0;
    drive_n(12);
    cur.resume = 1; drive(cur);
    cur.resume = 0; cur.mem_access = 0; drive_n(6);

    // Breakpoint at pc 3, resume once, run round to it again.
    cur.reset = 1; drive(cur);
    cur.reset = 0; cur.bp_en = 1; drive_n(15);
    cur.resume = 1; drive(cur);
    cur.resume = 0; drive_n(40);

    // Single step: park in WSTEP, step once, also toggle step mid-instruction.
    cur.bp_en = 0; cur.run = 0; cur.resume = 1; drive(cur);
    cur.resume = 0; drive_n(10);
    cur.step = 1; drive(cur);
    cur.step = 0; drive_n(2);
    cur.step = 1; drive(cur);
    cur.step = 0; drive_n(10);

    // Reset during a memory wait with no tick.
    cur.run = 1; cur.mem_access = 1; cur.mem_ready = 0;
    cur.step = 1; drive(cur);
    cur.step = 0; drive_n(6);
    cur.tick = 0; cur.reset = 1; drive(cur);
    cur.reset = 0; drive_n(3);

    // Randomised segments with varying tick and ready rates.
    for (int seg = 0; seg < 8; seg++) begin
      tick_pct  = 40 + 20 * (seg % 4);
      ready_pct = (seg % 2) ? 15 : 70;
      cur.bp_en = seg[1];
      cur.bp_addr = 16'($urandom_range(0, 7));
      for (int i = 0; i < 500; i++) begin
        cur.reset      = ($urandom % 400) == 0;
        cur.tick       = ($urandom % 100) < tick_pct;
        if (($urandom % 50) == 0) cur.run = ~cur.run;
        if (($urandom % 8) == 0) cur.step = ~cur.step;
        if (($urandom % 8) == 0) cur.resume = ~cur.resume;
        cur.halt_cmd   = ($urandom % 100) < 3;
        cur.rst_cmd    = ($urandom % 100) < 2;
        cur.mem_access = $urandom % 2;
        cur.mem_ready  = ($urandom % 100) < ready_pct;
        drive(cur);
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
